// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode and FSM state definitions shared by the sequential ALU
package alu_pkg;

    localparam int OP_LAST = 12;

    typedef enum logic [4:0] {
        OP_ADD = 5'd0,
        OP_SUB = 5'd1,
        OP_MUL = 5'd2,
        OP_DIV = 5'd3,
        OP_AND = 5'd4,
        OP_OR  = 5'd5,
        OP_NOT = 5'd6,
        OP_NEG = 5'd7,
        OP_SHL = 5'd8,
        OP_SHR = 5'd9,
        OP_SRA = 5'd10,
        OP_ROL = 5'd11,
        OP_ROR = 5'd12
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_BUSY = 2'd1,
        ST_DIV_BUSY = 2'd2
    } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// rtl/alu_muldiv_iter.sv - shared WIDTH-step shift-add multiply / restoring divide engine
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         load operands and begin an operation
//   mode          0 = multiply (shift-add), 1 = divide (restoring); sampled at start
//   a, b          operands, sampled at start
//   last          final iteration is being computed this cycle (count == 1)
//   hi, lo        combinational outcome of the current iteration; while last is
//                 high these are the finished HI:LO (product, or remainder:quotient)
module alu_muldiv_iter #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = SHW + 1;

    logic [WIDTH-1:0] acc;      // product high half / partial remainder
    logic [WIDTH-1:0] q;        // multiplier shifting out / quotient shifting in
    logic [WIDTH-1:0] d;        // multiplicand / divisor
    logic             mode_q;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] step_acc;
    logic [WIDTH-1:0] step_q;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_rem;
    logic             div_borrow;

    // One iteration of whichever algorithm is active. The last iteration is
    // never registered here; the top captures it directly from hi/lo, which
    // is what lets the result appear WIDTH-1 edges after acceptance.
    always_comb begin
        mul_sum   = {1'b0, acc} + (q[0] ? {1'b0, d} : {(WIDTH+1){1'b0}});
        div_shift = {acc, q[WIDTH-1]};
        {div_borrow, div_rem} = {1'b0, div_shift} - {2'b00, d};
        if (mode_q) begin
            // With d = 0 the subtraction never borrows, so the quotient fills
            // with ones and the dividend bits shift into the remainder intact.
            step_acc = WIDTH'(div_borrow ? div_shift : div_rem);
            step_q   = {q[WIDTH-2:0], ~div_borrow};
        end else begin
            step_acc = mul_sum[WIDTH:1];
            step_q   = {mul_sum[0], q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            q      <= '0;
            d      <= '0;
            mode_q <= 1'b0;
            count  <= '0;
        end else if (start) begin
            acc    <= '0;
            q      <= mode ? a : b;
            d      <= mode ? b : a;
            mode_q <= mode;
            count  <= CW'(WIDTH);
        end else if (count != '0) begin
            acc   <= step_acc;
            q     <= step_q;
            count <= count - 1'b1;
        end
    end

    assign last = (count == CW'(1));
    assign hi   = step_acc;
    assign lo   = step_q;

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle ALU: single-cycle logic/shift ops, iterative MUL/DIV
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   in_valid      op/a/b valid; accepted when in_ready is also high
//   in_ready      block can take an operation this cycle
//   op            opcode (alu_pkg::op_t values, > OP_LAST is illegal)
//   a, b          operands
//   out_valid     one-cycle pulse: result and flags are new
//   result        HI:LO, held until the next out_valid
//   div_by_zero   DIV with b = 0, qualified by out_valid
//   illegal_op    op > OP_LAST, qualified by out_valid
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    output logic [2*WIDTH-1:0] result,
    output logic               div_by_zero,
    output logic               illegal_op
);

    state_t state;
    state_t state_nx;

    logic               accept;
    logic               is_mul;
    logic               is_div;
    logic               is_single;
    logic               op_illegal;
    logic               eng_last;
    logic               fin;
    logic [WIDTH-1:0]   eng_hi;
    logic [WIDTH-1:0]   eng_lo;

    logic [SHW-1:0]     amt;
    logic [2*WIDTH-1:0] dbl_l;
    logic [2*WIDTH-1:0] dbl_r;
    logic [WIDTH-1:0]   single_lo;

    logic               out_valid_q;
    logic               ill_q;
    logic               bz_q;
    logic [2*WIDTH-1:0] result_q;

    assign is_mul     = (op == OP_MUL);
    assign is_div     = (op == OP_DIV);
    assign is_single  = !is_mul && !is_div;
    assign op_illegal = (op > 5'(OP_LAST));

    // The engine's final iteration is computed combinationally in the cycle
    // where it reports last, so the block is ready again in that same cycle.
    assign in_ready = (state == ST_IDLE) || eng_last;
    assign accept   = in_valid && in_ready && !rst;
    assign fin      = (state != ST_IDLE) && eng_last && !rst;

    alu_muldiv_iter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_muldiv (
        .clk   (clk),
        .rst   (rst),
        .start (accept && !is_single),
        .mode  (is_div),
        .a     (a),
        .b     (b),
        .last  (eng_last),
        .hi    (eng_hi),
        .lo    (eng_lo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (fin) begin
            state_nx = ST_IDLE;
        end
        if (accept) begin
            if (is_mul) begin
                state_nx = ST_MUL_BUSY;
            end else if (is_div) begin
                state_nx = ST_DIV_BUSY;
            end else begin
                state_nx = ST_IDLE;
            end
        end
    end

    // Rotates come from a doubled operand so a zero amount needs no special case.
    always_comb begin
        amt       = b[SHW-1:0];
        dbl_l     = {a, a} << amt;
        dbl_r     = {a, a} >> amt;
        single_lo = '0;
        case (op)
            OP_ADD:  single_lo = a + b;
            OP_SUB:  single_lo = a - b;
            OP_AND:  single_lo = a & b;
            OP_OR:   single_lo = a | b;
            OP_NOT:  single_lo = ~a;
            OP_NEG:  single_lo = -a;
            OP_SHL:  single_lo = a << amt;
            OP_SHR:  single_lo = a >> amt;
            OP_SRA:  single_lo = $signed(a) >>> amt;
            OP_ROL:  single_lo = dbl_l[2*WIDTH-1:WIDTH];
            OP_ROR:  single_lo = dbl_r[WIDTH-1:0];
            default: single_lo = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            ill_q       <= 1'b0;
            bz_q        <= 1'b0;
            result_q    <= '0;
        end else begin
            out_valid_q <= accept && is_single;
            ill_q       <= accept && op_illegal;
            if (fin) begin
                result_q <= {eng_hi, eng_lo};
            end
            if (accept && is_div) begin
                bz_q <= (b == '0);
            end
            // A single-cycle op accepted on a completion edge owns the next
            // out_valid, so its result takes the register.
            if (accept && is_single) begin
                result_q <= {{WIDTH{1'b0}}, single_lo};
            end
        end
    end

    assign out_valid   = out_valid_q || fin;
    assign result      = fin ? {eng_hi, eng_lo} : result_q;
    assign div_by_zero = fin && (state == ST_DIV_BUSY) && bz_q;
    assign illegal_op  = ill_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq with a behavioural reference model
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  op = 5'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        out_valid;
    logic [63:0] result;
    logic        div_by_zero;
    logic        illegal_op;

    alu_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .result      (result),
        .div_by_zero (div_by_zero),
        .illegal_op  (illegal_op)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [63:0] res;
        logic        dbz;
        logic        ill;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic exp_t model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t            e;
        longint unsigned xl;
        longint unsigned yl;
        longint unsigned mask;
        int unsigned     s;
        xl    = 64'(x);
        yl    = 64'(y);
        mask  = 64'hFFFF_FFFF;
        s     = 32'(y[4:0]);
        e.res = 64'd0;
        e.dbz = 1'b0;
        e.ill = 1'b0;
        e.acc = 0;
        e.lat = (o == 5'd2 || o == 5'd3) ? 31 : 0;
        case (o)
            5'd0:  e.res = (xl + yl) & mask;
            5'd1:  e.res = (xl - yl) & mask;
            5'd2:  e.res = xl * yl;
            5'd3:  if (y == 32'd0) begin
                       e.res = {x, 32'hFFFF_FFFF};
                       e.dbz = 1'b1;
                   end else begin
                       e.res = ((xl % yl) << 32) | (xl / yl);
                   end
            5'd4:  e.res = xl & yl;
            5'd5:  e.res = xl | yl;
            5'd6:  e.res = (~xl) & mask;
            5'd7:  e.res = (64'd0 - xl) & mask;
            5'd8:  e.res = (xl << s) & mask;
            5'd9:  e.res = xl >> s;
            5'd10: e.res = x[31] ? ((xl >> s) | (mask & ~(mask >> s))) : (xl >> s);
            5'd11: e.res = ((xl << s) | (xl >> (32 - s))) & mask;
            5'd12: e.res = ((xl >> s) | (xl << (32 - s))) & mask;
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit push, output int waited);
        exp_t e;
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        waited   = 0;
        while (in_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) begin
            total++;
            bad++;
            $display("FAIL issue_timeout: in_ready stayed %b, required 1 within 200 cycles", in_ready);
        end else if (push) begin
            e     = model(o, x, y);
            e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    exp_t m;
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out_valid: got result %h, required no output (cycle %0d)", result, cyc);
            end else begin
                m = sb.pop_front();
                chk("result", result, m.res);
                chk("div_by_zero", 64'(div_by_zero), 64'(m.dbz));
                chk("illegal_op", 64'(illegal_op), 64'(m.ill));
                chk("latency", 64'(cyc - m.acc), 64'(m.lat));
            end
        end else if (!rst) begin
            chk("idle_flags", {62'd0, div_by_zero, illegal_op}, 64'd0);
        end
    end

    int w;
    int t;
    logic [4:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_result", result, 64'd0);
        chk("reset_flags", {62'd0, div_by_zero, illegal_op}, 64'd0);

        issue(5'd0, 32'hFFFF_FFFF, 32'd1, 1, w);
        issue(5'd1, 32'd5, 32'd7, 1, w);

        issue(5'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, w);
        issue(5'd0, 32'd1, 32'd1, 1, w);
        chk("mul_ready_low_cycles", 64'(w), 64'd31);

        issue(5'd3, 32'd100, 32'd7, 1, w);
        issue(5'd3, 32'h1234, 32'd0, 1, w);
        chk("div_ready_low_cycles", 64'(w), 64'd31);
        issue(5'd0, 32'd9, 32'd1, 1, w);
        chk("div0_ready_low_cycles", 64'(w), 64'd31);

        issue(5'd10, 32'h8000_0000, 32'd4, 1, w);
        issue(5'd12, 32'h0000_0001, 32'd1, 1, w);
        issue(5'd11, 32'hDEAD_BEEF, 32'd0, 1, w);
        issue(5'd8, 32'h0000_0001, 32'd33, 1, w);
        issue(5'd20, 32'h1111_1111, 32'h2222_2222, 1, w);

        issue(5'd2, 32'd5, 32'd7, 0, w);
        repeat (8) @(negedge clk);
        chk("busy_before_reset", 64'(in_ready), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_result", result, 64'd0);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        repeat (40) @(negedge clk);
        issue(5'd0, 32'd2, 32'd3, 1, w);

        for (int i = 0; i < 80; i++) begin
            ro = 5'($urandom_range(0, 19));
            if (ro > 5'd15) ro = 5'($urandom_range(13, 31));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) rb = $urandom_range(0, 9);
            if ($urandom_range(0, 7) == 0) ra = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFFF : 32'd0;
            issue(ro, ra, rb, 1, w);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending results, required 0", sb.size());
        end
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
